mx_int_dot_acc: RTL

//   Accumulates a stream of signed integer products (as emitted by the int multiplier) into one dot-product sum per MX block.

---
 rtl/mx_arith_pkg.sv | 16 +
 rtl/acc_out_reg.sv | 31 +++
 rtl/mx_int_dot_acc.sv | 60 ++++++
 3 files changed

// File: rtl/mx_arith_pkg.sv
// mx_arith_pkg: shared MX arithmetic sizing helpers and default block constants.
package mx_arith_pkg;

    localparam int MX_BLOCK_SIZE     = 32;
    localparam int MX_INT8_PRD_WIDTH = 16;

    // Sum width that cannot overflow for blk products of prd_w bits each.
    function automatic int acc_width(input int prd_w, input int blk);
        return prd_w + $clog2(blk);
    endfunction

    function automatic int cnt_width(input int blk);
        return (blk > 1) ? $clog2(blk) : 1;
    endfunction

endpackage

// File: rtl/acc_out_reg.sv
// acc_out_reg: one-entry valid/ready holding register; a load wins over a drain in the same cycle.
module acc_out_reg #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_drain,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= i_load | (r_valid & ~i_drain);
            if (i_load)
                r_data <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/mx_int_dot_acc.sv
// mx_int_dot_acc: sums BLOCK_SIZE signed products into one dot-product result per MX block.
module mx_int_dot_acc
    import mx_arith_pkg::*;
#(
    parameter int PRD_WIDTH  = MX_INT8_PRD_WIDTH,
    parameter int BLOCK_SIZE = MX_BLOCK_SIZE,
    parameter int ACC_WIDTH  = acc_width(PRD_WIDTH, BLOCK_SIZE),
    localparam int CNT_W     = cnt_width(BLOCK_SIZE)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_prd_valid,
    output logic                 o_prd_ready,
    input  logic [PRD_WIDTH-1:0] i_prd,
    input  logic                 i_clear,
    output logic                 o_sum_valid,
    input  logic                 i_sum_ready,
    output logic [ACC_WIDTH-1:0] o_sum,
    output logic [CNT_W-1:0]     o_count
);

    logic [ACC_WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 w_last;
    logic                 w_accept;
    logic                 w_load;
    logic [ACC_WIDTH-1:0] w_sum;

    assign w_last      = (r_cnt == CNT_W'(BLOCK_SIZE - 1));
    // Only the final beat can stall, and a same-cycle drain frees the slot for it.
    assign o_prd_ready = i_rst_n & ~i_clear & (~w_last | ~o_sum_valid | i_sum_ready);
    assign w_accept    = i_prd_valid & o_prd_ready;
    assign w_load      = w_accept & w_last;
    assign w_sum       = r_acc + ACC_WIDTH'($signed(i_prd));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear || w_load) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    acc_out_reg #(
        .W(ACC_WIDTH)
    ) u_out (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_load),
        .i_data  (w_sum),
        .i_drain (i_sum_ready),
        .o_valid (o_sum_valid),
        .o_data  (o_sum)
    );

    assign o_count = r_cnt;

endmodule
